// File: rtl/coms_status_rx.sv
// Host-side UART status-frame receiver: 8N1 deserialiser feeding a frame parser
// that checks the checksum and publishes position/velocity/displacement/current.
module coms_status_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_CLKS = 320,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rx_i,
  output logic [7:0]  motor_id,
  output logic [31:0] position,
  output logic [31:0] velocity,
  output logic [31:0] displacement,
  output logic [31:0] current,
  output logic        status_valid,
  output logic        crc_error,
  output logic        frame_error
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_CNT  = TW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_HUNT, P_ID, P_PAYLOAD, P_CHECK} par_state_t;

  logic rx_s1_q, rx_s2_q, rx_d_q;

  bit_state_t    bit_state_q, bit_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_done_q, byte_done_d;
  logic          byte_err_q, byte_err_d;

  par_state_t    par_state_q, par_state_d;
  logic [7:0]    acc_q, acc_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    id_sh_q, id_sh_d;
  logic [127:0]  shadow_q, shadow_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [7:0]  motor_id_d;
  logic [31:0] position_d, velocity_d, displacement_d, current_d;
  logic        status_valid_d, crc_error_d, frame_error_d;

  // Bit engine: start-bit qualification at mid-bit, then one sample per bit period
  always_comb begin
    bit_state_d = bit_state_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    shreg_d     = shreg_q;
    byte_done_d = 1'b0;
    byte_err_d  = 1'b0;
    case (bit_state_q)
      B_IDLE: begin
        if (rx_d_q && !rx_s2_q) begin
          bit_state_d = B_START;
          cnt_d       = '0;
        end
      end
      B_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d       = '0;
          bidx_d      = '0;
          bit_state_d = rx_s2_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shreg_d = {rx_s2_q, shreg_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) bit_state_d = B_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          byte_done_d = rx_s2_q;
          byte_err_d  = !rx_s2_q;
          bit_state_d = B_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: bit_state_d = B_IDLE;
    endcase
  end

  // Frame parser; data outputs only move on a frame whose checksum matches
  always_comb begin
    par_state_d    = par_state_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    id_sh_d        = id_sh_q;
    shadow_d       = shadow_q;
    motor_id_d     = motor_id;
    position_d     = position;
    velocity_d     = velocity;
    displacement_d = displacement;
    current_d      = current;
    status_valid_d = 1'b0;
    crc_error_d    = 1'b0;
    frame_error_d  = 1'b0;
    timer_d        = timer_q;

    if (byte_done_q || par_state_q == P_HUNT) timer_d = '0;
    else if (timer_q != TMO_CNT)              timer_d = timer_q + TW'(1);

    if (byte_done_q) begin
      case (par_state_q)
        P_HUNT: begin
          if (shreg_q == SYNC_BYTE) begin
            par_state_d = P_ID;
            acc_d       = '0;
          end
        end
        P_ID: begin
          id_sh_d     = shreg_q;
          acc_d       = acc_q + shreg_q;
          idx_d       = '0;
          par_state_d = P_PAYLOAD;
        end
        P_PAYLOAD: begin
          shadow_d[{idx_q, 3'b000} +: 8] = shreg_q;
          acc_d = acc_q + shreg_q;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) par_state_d = P_CHECK;
        end
        P_CHECK: begin
          if (shreg_q == acc_q) begin
            motor_id_d     = id_sh_q;
            position_d     = shadow_q[31:0];
            velocity_d     = shadow_q[63:32];
            displacement_d = shadow_q[95:64];
            current_d      = shadow_q[127:96];
            status_valid_d = 1'b1;
          end else begin
            crc_error_d = 1'b1;
          end
          par_state_d = P_HUNT;
        end
        default: par_state_d = P_HUNT;
      endcase
    end else if (par_state_q != P_HUNT && (byte_err_q || timer_q == TMO_CNT)) begin
      frame_error_d = 1'b1;
      par_state_d   = P_HUNT;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_d_q       <= 1'b1;
      bit_state_q  <= B_IDLE;
      cnt_q        <= '0;
      bidx_q       <= '0;
      shreg_q      <= '0;
      byte_done_q  <= 1'b0;
      byte_err_q   <= 1'b0;
      par_state_q  <= P_HUNT;
      acc_q        <= '0;
      idx_q        <= '0;
      id_sh_q      <= '0;
      shadow_q     <= '0;
      timer_q      <= '0;
      motor_id     <= '0;
      position     <= '0;
      velocity     <= '0;
      displacement <= '0;
      current      <= '0;
      status_valid <= 1'b0;
      crc_error    <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_s1_q      <= rx_i;
      rx_s2_q      <= rx_s1_q;
      rx_d_q       <= rx_s2_q;
      bit_state_q  <= bit_state_d;
      cnt_q        <= cnt_d;
      bidx_q       <= bidx_d;
      shreg_q      <= shreg_d;
      byte_done_q  <= byte_done_d;
      byte_err_q   <= byte_err_d;
      par_state_q  <= par_state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      id_sh_q      <= id_sh_d;
      shadow_q     <= shadow_d;
      timer_q      <= timer_d;
      motor_id     <= motor_id_d;
      position     <= position_d;
      velocity     <= velocity_d;
      displacement <= displacement_d;
      current      <= current_d;
      status_valid <= status_valid_d;
      crc_error    <= crc_error_d;
      frame_error  <= frame_error_d;
    end
  end

endmodule

// File: tb/tb_coms_status_rx.sv
// Directed bench for coms_status_rx: drives UART frames on rx_i and checks the
// decoded words and the status/crc/frame strobes.
module tb_coms_status_rx;

  localparam int CPB = 16;

  typedef logic [7:0] frame_t [19];

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [7:0]  motor_id;
  logic [31:0] position, velocity, displacement, current;
  logic        status_valid, crc_error, frame_error;

  int n_vec = 0;
  int n_err = 0;
  int sv_cnt = 0, crc_cnt = 0, fe_cnt = 0, multi_cnt = 0;
  logic [31:0] pos_q[$];

  coms_status_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(320), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .reset(rst_n), .rx_i(rx),
    .motor_id(motor_id), .position(position), .velocity(velocity),
    .displacement(displacement), .current(current),
    .status_valid(status_valid), .crc_error(crc_error), .frame_error(frame_error)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (status_valid) begin
      sv_cnt++;
      pos_q.push_back(position);
    end
    if (crc_error)   crc_cnt++;
    if (frame_error) fe_cnt++;
    if ((int'(status_valid) + int'(crc_error) + int'(frame_error)) > 1) multi_cnt++;
  end

  task automatic build_frame(input logic [7:0] id, input logic [31:0] p, input logic [31:0] v,
                             input logic [31:0] d, input logic [31:0] c, output frame_t f);
    logic [127:0] pl;
    logic [7:0]   sum;
    pl   = {c, d, v, p};
    f[0] = 8'hA5;
    f[1] = id;
    sum  = id;
    for (int i = 0; i < 16; i++) begin
      f[2+i] = pl[8*i +: 8];
      sum    = sum + pl[8*i +: 8];
    end
    f[18] = sum;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge CLK);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge CLK);
    end
  endtask

  task automatic send_range(input frame_t f, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(f[i], 1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge CLK);
    n_vec++; if (position !== 32'd0) begin n_err++; $display("FAIL reset_position got %h exp 0", position); end
    n_vec++; if (velocity !== 32'd0) begin n_err++; $display("FAIL reset_velocity got %h exp 0", velocity); end
    n_vec++; if (displacement !== 32'd0) begin n_err++; $display("FAIL reset_displacement got %h exp 0", displacement); end
    n_vec++; if (current !== 32'd0) begin n_err++; $display("FAIL reset_current got %h exp 0", current); end
    n_vec++; if (motor_id !== 8'd0) begin n_err++; $display("FAIL reset_motor_id got %h exp 0", motor_id); end
    n_vec++; if ({status_valid, crc_error, frame_error} !== 3'b000) begin
      n_err++; $display("FAIL reset_strobes got %b exp 000", {status_valid, crc_error, frame_error});
    end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_crc_error;
    frame_t f;
    int sv0, crc0;
    build_frame(8'h03, 32'd1, 32'd2, 32'd3, 32'd4, f);
    f[18] = 8'h0E;
    sv0 = sv_cnt; crc0 = crc_cnt;
    send_range(f, 0, 18);
    idle(30);
    n_vec++; if (crc_cnt - crc0 !== 1) begin n_err++; $display("FAIL crc_pulses got %0d exp 1", crc_cnt - crc0); end
    n_vec++; if (sv_cnt - sv0 !== 0) begin n_err++; $display("FAIL crc_status_valid got %0d exp 0", sv_cnt - sv0); end
    n_vec++; if (position !== 32'd0) begin n_err++; $display("FAIL crc_position_held got %h exp 0", position); end
    n_vec++; if (motor_id !== 8'd0) begin n_err++; $display("FAIL crc_motor_id_held got %h exp 0", motor_id); end
  endtask

  task automatic test_good_frame;
    frame_t f;
    int sv0;
    f = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
          8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h0D};
    sv0 = sv_cnt;
    pos_q.delete();
    send_range(f, 0, 18);
    idle(30);
    n_vec++; if (sv_cnt - sv0 !== 1) begin n_err++; $display("FAIL good_pulses got %0d exp 1", sv_cnt - sv0); end
    n_vec++; if (position !== 32'd1) begin n_err++; $display("FAIL good_position got %h exp 1", position); end
    n_vec++; if (velocity !== 32'd2) begin n_err++; $display("FAIL good_velocity got %h exp 2", velocity); end
    n_vec++; if (displacement !== 32'd3) begin n_err++; $display("FAIL good_displacement got %h exp 3", displacement); end
    n_vec++; if (current !== 32'd4) begin n_err++; $display("FAIL good_current got %h exp 4", current); end
    n_vec++; if (motor_id !== 8'd3) begin n_err++; $display("FAIL good_motor_id got %h exp 3", motor_id); end
    n_vec++; if (pos_q.size() != 1 || pos_q[0] !== 32'd1) begin
      n_err++; $display("FAIL good_position_at_strobe got size %0d exp position 1 at strobe", pos_q.size());
    end
  endtask

  task automatic test_glitch;
    int s0;
    s0 = sv_cnt + crc_cnt + fe_cnt;
    rx = 1'b0;
    repeat (5) @(negedge CLK);
    idle(300);
    n_vec++; if (sv_cnt + crc_cnt + fe_cnt - s0 !== 0) begin
      n_err++; $display("FAIL glitch_strobes got %0d exp 0", sv_cnt + crc_cnt + fe_cnt - s0);
    end
  endtask

  task automatic test_garbage;
    frame_t f;
    int sv0, e0;
    build_frame(8'h07, 32'h11, 32'h22, 32'h33, 32'h44, f);
    sv0 = sv_cnt; e0 = crc_cnt + fe_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    send_range(f, 0, 18);
    idle(30);
    n_vec++; if (sv_cnt - sv0 !== 1) begin n_err++; $display("FAIL garbage_pulses got %0d exp 1", sv_cnt - sv0); end
    n_vec++; if (crc_cnt + fe_cnt - e0 !== 0) begin n_err++; $display("FAIL garbage_errors got %0d exp 0", crc_cnt + fe_cnt - e0); end
    n_vec++; if ({motor_id, position, current} !== {8'h07, 32'h11, 32'h44}) begin
      n_err++; $display("FAIL garbage_decode got id %h pos %h cur %h exp 07 11 44", motor_id, position, current);
    end
  endtask

  task automatic test_stop_error;
    frame_t f, g;
    int sv0, fe0;
    build_frame(8'h09, 32'hAAAA0001, 32'h5, 32'h6, 32'h7, f);
    build_frame(8'h0A, 32'h00C0FFEE, 32'h8, 32'h9, 32'hA, g);
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_range(f, 0, 8);
    send_byte(f[9], 1'b0);
    send_range(f, 10, 18);
    idle(30);
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL stop_frame_error got %0d exp 1", fe_cnt - fe0); end
    n_vec++; if (sv_cnt - sv0 !== 0) begin n_err++; $display("FAIL stop_no_valid got %0d exp 0", sv_cnt - sv0); end
    send_range(g, 0, 18);
    idle(30);
    n_vec++; if (sv_cnt - sv0 !== 1 || position !== 32'h00C0FFEE) begin
      n_err++; $display("FAIL stop_recover got pulses %0d pos %h exp 1 00c0ffee", sv_cnt - sv0, position);
    end
  endtask

  task automatic test_timeout;
    frame_t f, g;
    int sv0, fe0;
    build_frame(8'h0B, 32'h1, 32'h2, 32'h3, 32'h4, f);
    build_frame(8'h0C, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, g);
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_range(f, 0, 10);
    idle(400);
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL timeout_frame_error got %0d exp 1", fe_cnt - fe0); end
    send_range(g, 0, 18);
    idle(30);
    n_vec++; if (sv_cnt - sv0 !== 1 || position !== 32'h0BADF00D || motor_id !== 8'h0C) begin
      n_err++; $display("FAIL timeout_recover got pulses %0d pos %h id %h exp 1 0badf00d 0c", sv_cnt - sv0, position, motor_id);
    end
  endtask

  task automatic test_back_to_back;
    frame_t f, g;
    int sv0;
    build_frame(8'h01, 32'h12345678, 32'h0, 32'h0, 32'h0, f);
    build_frame(8'h02, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, g);
    sv0 = sv_cnt;
    pos_q.delete();
    send_range(f, 0, 18);
    send_range(g, 0, 18);
    idle(30);
    n_vec++; if (sv_cnt - sv0 !== 2) begin n_err++; $display("FAIL b2b_pulses got %0d exp 2", sv_cnt - sv0); end
    n_vec++; if (pos_q.size() < 1 || pos_q[0] !== 32'h12345678) begin
      n_err++; $display("FAIL b2b_first_position got %h exp 12345678", (pos_q.size() > 0) ? pos_q[0] : 32'hX);
    end
    n_vec++; if (pos_q.size() < 2 || pos_q[1] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL b2b_second_position got %h exp deadbeef", (pos_q.size() > 1) ? pos_q[1] : 32'hX);
    end
  endtask

  task automatic test_reset_mid_frame;
    frame_t f, g;
    int sv0;
    build_frame(8'h05, 32'h55667788, 32'h1, 32'h1, 32'h1, f);
    build_frame(8'h06, 32'h0000CAFE, 32'h2, 32'h3, 32'h4, g);
    send_range(f, 0, 11);
    rx = 1'b0;
    repeat (CPB + 3 * CPB) @(negedge CLK);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge CLK);
    n_vec++; if ({position, motor_id, status_valid} !== 41'd0) begin
      n_err++; $display("FAIL rst_mid_outputs got pos %h id %h sv %b exp 0", position, motor_id, status_valid);
    end
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    sv0 = sv_cnt;
    pos_q.delete();
    idle(400);
    n_vec++; if (sv_cnt - sv0 !== 0 || position !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_no_valid got pulses %0d pos %h exp 0 0", sv_cnt - sv0, position);
    end
    send_range(g, 0, 18);
    idle(30);
    n_vec++; if (sv_cnt - sv0 !== 1 || position !== 32'h0000CAFE || current !== 32'h4) begin
      n_err++; $display("FAIL rst_mid_post_frame got pulses %0d pos %h cur %h exp 1 0000cafe 4", sv_cnt - sv0, position, current);
    end
  endtask

  task automatic test_exclusive;
    n_vec++; if (multi_cnt !== 0) begin n_err++; $display("FAIL strobe_exclusive got %0d overlapping cycles exp 0", multi_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset;
    test_crc_error;
    test_good_frame;
    test_glitch;
    test_garbage;
    test_stop_error;
    test_timeout;
    test_back_to_back;
    test_reset_mid_frame;
    test_exclusive;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
